// File: rtl/clcd_cmd_arbiter.sv
// clcd_cmd_arbiter
// Grants one of three byte-command requesters at a time, latches the winning byte and runs
// the valid/busy handshake with CLCD_signal_generator. Supports locked bursts and times out
// a signal generator that never raises busy.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   i_req_valid/RS/RW/lock [2:0]    per-requester request, RS, RW, keep-ownership
//   i_req_data [23:0]               byte k at [8k+7:8k]
//   o_req_ack [2:0]                 one-cycle completion (or timeout) pulse per requester
//   o_data, o_RS, o_RW, o_valid     command to the signal generator
//   i_busy                          busy from the signal generator
//   o_grant [1:0]                   current/last owner, 2'b11 = none
//   o_timeout, o_err, i_err_clr     timeout pulse, sticky error flag and its clear
module clcd_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned TO_W        = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  i_req_valid,
    input  logic [23:0] i_req_data,
    input  logic [2:0]  i_req_RS,
    input  logic [2:0]  i_req_RW,
    input  logic [2:0]  i_req_lock,
    output logic [2:0]  o_req_ack,
    output logic [7:0]  o_data,
    output logic        o_RS,
    output logic        o_RW,
    output logic        o_valid,
    input  logic        i_busy,
    output logic [1:0]  o_grant,
    output logic        o_timeout,
    output logic        o_err,
    input  logic        i_err_clr
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_grant;
    logic [1:0]       w_grant_next;
    logic             r_rr_last2;    // 1: requester 2 was granted most recently, favour 1
    logic             w_rr_next;
    logic [TO_W-1:0]  r_cnt;
    logic [TO_W-1:0]  w_cnt_next;
    logic             r_timeout;
    logic             w_timeout_next;
    logic             r_err;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_rw;

    logic             w_held;
    logic             w_lock_own;
    logic [2:0]       w_own_oh;
    logic [2:0]       w_elig;
    logic             w_go;
    logic [1:0]       w_sel;

    // Owner decode; 2'b11 maps to no owner.
    always_comb begin
        w_own_oh   = 3'b000;
        w_lock_own = 1'b0;
        case (r_grant)
            2'd0:    begin w_own_oh = 3'b001; w_lock_own = i_req_lock[0]; end
            2'd1:    begin w_own_oh = 3'b010; w_lock_own = i_req_lock[1]; end
            2'd2:    begin w_own_oh = 3'b100; w_lock_own = i_req_lock[2]; end
            default: begin w_own_oh = 3'b000; w_lock_own = 1'b0;          end
        endcase
    end

    assign w_held = (r_grant != 2'b11);

    // A locked owner excludes everyone else; otherwise all requesters compete.
    assign w_elig = (w_held && w_lock_own) ? (i_req_valid & w_own_oh) : i_req_valid;

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_rr_next      = r_rr_last2;
        w_cnt_next     = r_cnt;
        w_timeout_next = 1'b0;
        w_go           = 1'b0;
        w_sel          = 2'd0;

        unique case (r_state)
            StIdle: begin
                if (!i_busy) begin
                    if (w_held && !w_lock_own) begin
                        w_grant_next = 2'b11;
                    end
                    if (w_elig[0]) begin
                        w_go  = 1'b1;
                        w_sel = 2'd0;
                    end else if (w_elig[1] && (!w_elig[2] || r_rr_last2)) begin
                        w_go  = 1'b1;
                        w_sel = 2'd1;
                    end else if (w_elig[2]) begin
                        w_go  = 1'b1;
                        w_sel = 2'd2;
                    end
                    if (w_go) begin
                        w_grant_next = w_sel;
                        w_state_next = StIssue;
                        w_cnt_next   = '0;
                        if (w_sel != 2'd0) begin
                            w_rr_next = (w_sel == 2'd2);
                        end
                    end
                end
            end
            StIssue: begin
                if (r_cnt != {TO_W{1'b1}}) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (i_busy) begin
                    w_state_next = StWait;
                end else if (r_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_state_next   = StDone;
                    w_timeout_next = 1'b1;
                end
            end
            StWait: begin
                if (!i_busy) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (!w_lock_own) begin
                    w_grant_next = 2'b11;
                end
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_grant    <= 2'b11;
            r_rr_last2 <= 1'b1;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= 8'h00;
            r_rs       <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_rr_last2 <= w_rr_next;
            r_cnt      <= w_cnt_next;
            r_timeout  <= w_timeout_next;
            // Timeout set wins over a same-cycle clear.
            if (w_timeout_next) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_go) begin
                r_data <= i_req_data[8*w_sel +: 8];
                r_rs   <= i_req_RS[w_sel];
                r_rw   <= i_req_RW[w_sel];
            end
        end
    end

    // Valid and ack decode straight from state so reset drops them immediately.
    assign o_valid   = (r_state == StIssue);
    assign o_req_ack = (r_state == StDone) ? w_own_oh : 3'b000;
    assign o_grant   = r_grant;
    assign o_data    = r_data;
    assign o_RS      = r_rs;
    assign o_RW      = r_rw;
    assign o_timeout = r_timeout;
    assign o_err     = r_err;

endmodule

// File: tb/tb_clcd_cmd_arbiter.sv
// Directed bench for clcd_cmd_arbiter, built with TIMEOUT_CYC=16.
module tb_clcd_cmd_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  i_req_valid;
    logic [23:0] i_req_data;
    logic [2:0]  i_req_RS;
    logic [2:0]  i_req_RW;
    logic [2:0]  i_req_lock;
    logic [2:0]  o_req_ack;
    logic [7:0]  o_data;
    logic        o_RS;
    logic        o_RW;
    logic        o_valid;
    logic        i_busy;
    logic [1:0]  o_grant;
    logic        o_timeout;
    logic        o_err;
    logic        i_err_clr;

    int n_vec = 0;
    int n_err = 0;

    clcd_cmd_arbiter #(
        .TIMEOUT_CYC (16),
        .TO_W        (4)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_RS    (i_req_RS),
        .i_req_RW    (i_req_RW),
        .i_req_lock  (i_req_lock),
        .o_req_ack   (o_req_ack),
        .o_data      (o_data),
        .o_RS        (o_RS),
        .o_RW        (o_RW),
        .o_valid     (o_valid),
        .i_busy      (i_busy),
        .o_grant     (o_grant),
        .o_timeout   (o_timeout),
        .o_err       (o_err),
        .i_err_clr   (i_err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=hang required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        i_req_valid = 3'b000;
        i_req_data  = 24'h0;
        i_req_RS    = 3'b000;
        i_req_RW    = 3'b000;
        i_req_lock  = 3'b000;
        i_busy      = 1'b0;
        i_err_clr   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Wait for o_valid, answer with a one-cycle busy, leave the DUT in its DONE cycle.
    task automatic serve(input logic [1:0] g_exp, input string tag);
        int n = 0;
        logic [2:0] oh;
        oh = 3'b001 << g_exp;
        while (!o_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_grant"}, 32'(o_grant), 32'(g_exp));
        i_busy = 1'b1;
        tick();
        chk({tag, "_wait_novalid"}, 32'(o_valid), 32'd0);
        i_busy = 1'b0;
        tick();
        chk({tag, "_ack"}, 32'(o_req_ack), 32'(oh));
    endtask

    initial begin
        int vcnt;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'h00);
        chk("rst_rs_rw", 32'({o_RS, o_RW}), 32'd0);
        chk("rst_ack", 32'(o_req_ack), 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd3);
        chk("rst_to_err", 32'({o_timeout, o_err}), 32'd0);

        // Single request from requester 1
        i_req_data  = 24'h004100;
        i_req_RS    = 3'b010;
        i_req_valid = 3'b010;
        tick();
        chk("single_valid1", 32'(o_valid), 32'd1);
        chk("single_data", 32'(o_data), 32'h41);
        chk("single_rs", 32'(o_RS), 32'd1);
        chk("single_grant", 32'(o_grant), 32'd1);
        i_req_data = 24'hFFFFFF;    // must not disturb latched byte
        tick();
        chk("single_valid2", 32'(o_valid), 32'd1);
        chk("single_data_held", 32'(o_data), 32'h41);
        i_busy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 0 || i == 49) begin
                chk("single_busy_novalid", 32'(o_valid), 32'd0);
                chk("single_busy_noack", 32'(o_req_ack), 32'd0);
            end
        end
        i_busy = 1'b0;
        tick();
        chk("single_ack", 32'(o_req_ack), 32'b010);
        i_req_valid = 3'b000;
        tick();
        chk("single_ack_once", 32'(o_req_ack), 32'd0);
        chk("single_release", 32'(o_grant), 32'd3);

        // Priority then round-robin
        do_reset();
        i_req_data  = 24'h333231;
        i_req_valid = 3'b111;
        serve(2'd0, "rr0a");
        serve(2'd0, "rr0b");
        i_req_valid = 3'b110;
        serve(2'd1, "rr1a");
        serve(2'd2, "rr2a");
        serve(2'd1, "rr1b");
        serve(2'd2, "rr2b");
        i_req_valid = 3'b000;
        tick();
        chk("rr_ack_single", 32'(o_req_ack), 32'd0);

        // Locked burst of 16 bytes from requester 1 with requester 2 waiting
        do_reset();
        i_req_valid = 3'b110;
        i_req_lock  = 3'b010;
        for (int i = 0; i < 16; i++) begin
            serve(2'd1, "lock_burst");
            if (i == 0) begin
                tick();
                chk("lock_owner_kept", 32'(o_grant), 32'd1);
            end
        end
        i_req_valid = 3'b100;
        i_req_lock  = 3'b000;
        tick();
        chk("lock_rel_grant", 32'(o_grant), 32'd3);
        chk("lock_rel_idle", 32'(o_valid), 32'd0);
        tick();
        chk("lock_rel_req2_now", 32'(o_valid), 32'd1);
        serve(2'd2, "lock_rel");
        i_req_valid = 3'b000;
        tick();

        // Timeout: busy never rises
        do_reset();
        i_req_data  = 24'h0000AA;
        i_req_valid = 3'b001;
        vcnt = 0;
        tick();
        while (o_valid && vcnt < 40) begin
            vcnt++;
            tick();
        end
        chk("to_valid_cycles", 32'(vcnt), 32'd16);
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_err_set", 32'(o_err), 32'd1);
        chk("to_ack", 32'(o_req_ack), 32'b001);
        i_req_valid = 3'b000;
        tick();
        chk("to_pulse_once", 32'(o_timeout), 32'd0);
        chk("to_err_sticky", 32'(o_err), 32'd1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("to_err_clr", 32'(o_err), 32'd0);

        // Busy while idle blocks the grant
        do_reset();
        i_busy      = 1'b1;
        i_req_valid = 3'b001;
        tick();
        tick();
        tick();
        chk("busyidle_block", 32'(o_valid), 32'd0);
        chk("busyidle_nogrant", 32'(o_grant), 32'd3);
        i_busy = 1'b0;
        tick();
        chk("busyidle_go", 32'(o_valid), 32'd1);
        serve(2'd0, "busyidle");
        i_req_valid = 3'b000;
        tick();

        // Reset in the middle of ISSUE
        do_reset();
        i_req_data  = 24'h5A0000;
        i_req_valid = 3'b100;
        tick();
        chk("rstmid_valid", 32'(o_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_drop", 32'(o_valid), 32'd0);
        chk("rstmid_grant", 32'(o_grant), 32'd3);
        chk("rstmid_noack", 32'(o_req_ack), 32'd0);
        tick();
        chk("rstmid_noack2", 32'(o_req_ack), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rstmid_regrant", 32'(o_grant), 32'd2);
        chk("rstmid_data", 32'(o_data), 32'h5A);
        serve(2'd2, "rstmid");
        i_req_valid = 3'b000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clcd_cmd_arbiter.md
# clcd_cmd_arbiter

Three-requester arbiter and sequencer for the CLCD byte-command interface that feeds CLCD_signal_generator. It replaces the static init/system mux: it grants one requester at a time, latches its byte, and runs the valid/busy handshake with the signal generator. It also supports locked bursts so a text line is never interleaved, and times out a missing busy response. Requester 0 is the init register, 1 is system control, 2 is an auxiliary command source.

## Interface
- TIMEOUT_CYC, 1024: max cycles o_valid may stay high without i_busy rising.
- TO_W, 10: timeout counter width; must satisfy 2^TO_W >= TIMEOUT_CYC.

- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  3  per-requester command request; held until matching o_req_ack
- i_req_data  in  24  byte k at [8k+7:8k]
- i_req_RS  in  3  per-requester RS
- i_req_RW  in  3  per-requester RW
- i_req_lock  in  3  requester k wants to keep ownership after its current byte
- o_req_ack  out  3  one-cycle pulse: byte of requester k completed or timed out
- o_data  out  8  byte to signal generator
- o_RS  out  1  RS to signal generator
- o_RW  out  1  RW to signal generator
- o_valid  out  1  command valid to signal generator
- i_busy  in  1  busy from signal generator
- o_grant  out  2  current/last owner index; 2'b11 = none
- o_timeout  out  1  one-cycle pulse on busy-rise timeout
- o_err  out  1  sticky timeout flag
- i_err_clr  in  1  synchronous clear of o_err

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitration runs only when i_busy=0.
  - If an owner is held and i_req_lock[owner]=1, only that requester is eligible. Otherwise the owner is released this cycle and normal arbitration applies.
  - Normal arbitration: requester 0 has fixed highest priority. Requesters 1 and 2 are round-robin; the one not most recently granted wins a tie. The round-robin pointer updates only on grants to 1 or 2.
  - On grant k: latch data, RS and RW into o_data, o_RS and o_RW; set o_grant=k; go to ISSUE.
- ISSUE:
  - o_valid=1 and the timeout counter increments each cycle.
  - When i_busy=1: o_valid=0, go to WAIT.
  - When the counter reaches TIMEOUT_CYC-1 with i_busy=0: o_valid=0, pulse o_timeout, set o_err, go to DONE.
- WAIT: hold until i_busy=0, then go to DONE. No timeout in WAIT.
- DONE:
  - Pulse o_req_ack[k] for one cycle.
  - If i_req_lock[k]=1, keep o_grant=k as owner; else set o_grant=2'b11.
  - Go to IDLE.
- Requester k must drop or update i_req_valid[k] the cycle after its ack. The arbiter ignores i_req_valid[k] during the DONE cycle.
- Latched data is stable from grant through DONE; requester input changes after grant have no effect.
- i_err_clr clears o_err. If a timeout and a clear occur in the same cycle, the set wins.
- Arithmetic: the timeout counter saturates and clears on entry to ISSUE.

## Timing
- Reset (async, reset_n=0), effective immediately:
  - o_valid=0, o_data=0, o_RS=0, o_RW=0
  - o_req_ack=0, o_grant=2'b11, o_timeout=0, o_err=0
  - state IDLE, round-robin pointer favours requester 1.
- Reset mid-transaction drops o_valid combinationally with reset; no ack is issued.
- Latency from i_req_valid rising (IDLE, i_busy=0) to o_valid=1: 1 cycle (grant registered on the first edge).
- o_valid falls on the edge after i_busy is sampled high.
- Ack occurs 1 cycle after i_busy is sampled low in WAIT.
- Minimum transaction (busy for 1 cycle): valid→busy 1 cycle, then WAIT 1, DONE 1. The next grant follows ack by ≥1 cycle.
- i_busy high while in IDLE (e.g. the previous I2C transfer is still draining): no grant until it is low.
- Simultaneous requests from all three with no owner: requester 0 is served first, then 1 and 2 alternate.
- Lock released in the same cycle as a new request from another requester: that request is eligible in the same IDLE cycle.

## Test plan
- Single request: req1 with data 0x41, RS=1, busy responding after 2 cycles and lasting 50 cycles:
  - o_valid high for 2 cycles, o_data=0x41, o_RS=1
  - one ack[1] pulse 1 cycle after busy falls.
- Priority and round-robin: req0, req1 and req2 held valid continuously:
  - grant order 0,0,… while req0 is valid; after req0 drops, 1,2,1,2.
  - Each ack is a single cycle.
- Lock burst: req1 sends 16 bytes with lock=1 while req2 is valid throughout:
  - all 16 bytes granted to 1 before any grant to 2
  - req2 is granted on the first IDLE after lock drops.
- Timeout with TIMEOUT_CYC=16: i_busy never rises:
  - o_valid high for exactly 16 cycles, then o_timeout pulse, o_err=1, ack to the requester.
  - i_err_clr then clears o_err.
- Busy at idle: i_busy=1 while req0 is valid: no o_valid until busy falls, then o_valid on the next cycle.
- Reset mid-ISSUE: assert reset_n=0 while o_valid=1:
  - o_valid drops immediately, no ack issued, o_grant=2'b11
  - after release, a pending request is re-arbitrated normally.
